// File: rtl/exec_stage_if.sv
// Execute-stage bus: upstream issue handshake, register-file writeback
// and in-flight MUL hazard information.
interface exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [AW-1:0]    rc_in;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             wb_en;
  logic [AW-1:0]    wb_rc;
  logic [WIDTH-1:0] wb_data;
  logic             pend_valid;
  logic [AW-1:0]    pend_rc;

  // Upstream issue logic / register file side
  modport master (
    output in_valid, op, rc_in, opa, opb,
    input  in_ready, wb_en, wb_rc, wb_data, pend_valid, pend_rc
  );

  // Execute stage side
  modport slave (
    input  in_valid, op, rc_in, opa, opb,
    output in_ready, wb_en, wb_rc, wb_data, pend_valid, pend_rc
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL
// that stalls upstream for WIDTH cycles; result goes out as a one-cycle
// registered writeback pulse.
module exec_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 3,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  exec_stage_if.slave  bus
);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7
  } op_t;

  state_t           r_state, w_state_next;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic             r_wb_en;
  logic [AW-1:0]    r_wb_rc;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_pend_valid;
  logic [AW-1:0]    r_pend_rc;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (op_t'(bus.op) == OP_MUL);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: enter MUL on an accepted MUL, leave after the last iteration
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:  if (w_mul_last)           w_state_next = S_IDLE;
      default:                          w_state_next = S_IDLE;
    endcase
  end

  // Output decode: ready depends on state only
  always_comb begin
    w_in_ready = (r_state == S_IDLE);
  end

  // Single-cycle ALU result
  always_comb begin
    w_alu_res = '0;
    unique case (op_t'(bus.op))
      OP_ADD: w_alu_res = bus.opa + bus.opb;
      OP_SUB: w_alu_res = bus.opa - bus.opb;
      OP_AND: w_alu_res = bus.opa & bus.opb;
      OP_OR:  w_alu_res = bus.opa | bus.opb;
      OP_XOR: w_alu_res = bus.opa ^ bus.opb;
      OP_SHL: w_alu_res = bus.opa << bus.opb[SHW-1:0];
      OP_SHR: w_alu_res = bus.opa >> bus.opb[SHW-1:0];
      OP_MUL: w_alu_res = '0;
      default: w_alu_res = '0;
    endcase
  end

  // Datapath: operand capture, shift-add iteration and writeback pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_wb_en      <= 1'b0;
      r_wb_rc      <= '0;
      r_wb_data    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rc    <= '0;
    end else begin
      r_wb_en <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_cnt        <= '0;
          r_acc        <= '0;
          r_mcand      <= bus.opa;
          r_mplier     <= bus.opb;
          r_pend_valid <= 1'b1;
          r_pend_rc    <= bus.rc_in;
        end else begin
          r_wb_en   <= 1'b1;
          r_wb_rc   <= bus.rc_in;
          r_wb_data <= w_alu_res;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHW'(1);
        // The final iteration's sum bypasses r_acc straight to writeback
        if (w_mul_last) begin
          r_wb_en      <= 1'b1;
          r_wb_rc      <= r_pend_rc;
          r_wb_data    <= w_acc_next;
          r_pend_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.wb_en      = r_wb_en;
  assign bus.wb_rc      = r_wb_rc;
  assign bus.wb_data    = r_wb_data;
  assign bus.pend_valid = r_pend_valid;
  assign bus.pend_rc    = r_pend_rc;

endmodule
